// File: rtl/rcc_pclk_div_ctrl.sv
// Programming-side sequencer for the RCC peripheral-clock divider: applies
// div_sel then timpre one at a time, holding a settle window after each change.
module rcc_pclk_div_ctrl #(
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned CNT_W       = 8,
  parameter logic [2:0]  RST_DIV_SEL = 3'b000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_div_sel,
  input  logic       req_timpre,
  output logic [2:0] div_sel,
  output logic       timpre,
  output logic       busy,
  output logic       upd_done,
  output logic [2:0] pclk_log2,
  output logic [2:0] tim_log2
);

  typedef enum logic [2:0] {
    IDLE,
    SW_DIV,
    WAIT_DIV,
    SW_TIM,
    WAIT_TIM,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       tgt_div_q, tgt_div_d;
  logic             tgt_tim_q, tgt_tim_d;
  logic [2:0]       div_sel_d;
  logic             timpre_d;
  logic             busy_d;
  logic             upd_done_d;
  logic             req_ready_d;

  // State, target and registered-output flops
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tgt_div_q <= RST_DIV_SEL;
      tgt_tim_q <= 1'b0;
      div_sel   <= RST_DIV_SEL;
      timpre    <= 1'b0;
      busy      <= 1'b0;
      upd_done  <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_div_q <= tgt_div_d;
      tgt_tim_q <= tgt_tim_d;
      div_sel   <= div_sel_d;
      timpre    <= timpre_d;
      busy      <= busy_d;
      upd_done  <= upd_done_d;
      req_ready <= req_ready_d;
    end
  end

  // Next-state logic; status flags are derived from the next state so they
  // line up with the state register without a combinational output path.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_div_d = tgt_div_q;
    tgt_tim_d = tgt_tim_q;
    div_sel_d = div_sel;
    timpre_d  = timpre;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          tgt_div_d = req_div_sel;
          tgt_tim_d = req_timpre;
          if (req_div_sel != div_sel) begin
            state_d = SW_DIV;
          end else if (req_timpre != timpre) begin
            state_d = SW_TIM;
          end else begin
            state_d = DONE;
          end
        end
      end
      SW_DIV: begin
        div_sel_d = tgt_div_q;
        cnt_d     = '0;
        state_d   = WAIT_DIV;
      end
      WAIT_DIV: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = (tgt_tim_q != timpre) ? SW_TIM : DONE;
        end
      end
      SW_TIM: begin
        timpre_d = tgt_tim_q;
        cnt_d    = '0;
        state_d  = WAIT_TIM;
      end
      WAIT_TIM: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    upd_done_d  = (state_d == DONE);
    req_ready_d = (state_d == IDLE);
  end

  // Divide-ratio decode from the registered selects
  always_comb begin
    pclk_log2 = 3'd0;
    tim_log2  = 3'd0;
    if (div_sel[2]) begin
      pclk_log2 = {1'b0, div_sel[1:0]} + 3'd1;
    end
    if (!timpre) begin
      tim_log2 = pclk_log2;
    end else if (div_sel[2] && div_sel[1]) begin
      tim_log2 = 3'd1 + {2'b00, div_sel[0]};
    end
  end

endmodule

// File: tb/tb_rcc_pclk_div_ctrl.sv
// Self-checking bench for rcc_pclk_div_ctrl: directed scenarios plus random
// requests checked against a ratio/latency reference model.
module tb_rcc_pclk_div_ctrl;

  localparam int unsigned S = 64;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_div_sel;
  logic       req_timpre;
  logic [2:0] div_sel;
  logic       timpre;
  logic       busy;
  logic       upd_done;
  logic [2:0] pclk_log2;
  logic [2:0] tim_log2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc    = 0;

  logic [2:0] cur_d;
  logic       cur_t;

  rcc_pclk_div_ctrl #(
    .SETTLE_CYC (S),
    .CNT_W      (8),
    .RST_DIV_SEL(3'b000)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_div_sel(req_div_sel),
    .req_timpre (req_timpre),
    .div_sel    (div_sel),
    .timpre     (timpre),
    .busy       (busy),
    .upd_done   (upd_done),
    .pclk_log2  (pclk_log2),
    .tim_log2   (tim_log2)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: pclk ratio = 1 or 2^(sel+1); timpre makes timers run 4x faster
  // than pclk, but never faster than the source clock.
  function automatic int ref_pclk(input logic [2:0] d);
    int ratio;
    int l;
    ratio = d[2] ? (2 << d[1:0]) : 1;
    l = 0;
    while ((1 << l) < ratio) l++;
    return l;
  endfunction

  function automatic int ref_tim(input logic [2:0] d, input logic t);
    int p;
    p = ref_pclk(d);
    if (!t) return p;
    return (p > 2) ? p - 2 : 0;
  endfunction

  task automatic start_req(input logic [2:0] nd, input logic nt);
    @(negedge clk_in);
    req_valid   = 1'b1;
    req_div_sel = nd;
    req_timpre  = nt;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    @(negedge clk_in);
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  // Follows one sequence from the negedge after its accept edge to completion.
  task automatic monitor(input logic [2:0] nd, input logic nt);
    logic [2:0] d0;
    logic       t0;
    int exp_lat, div_k, tim_k, done_k, k, bad;
    d0 = cur_d;
    t0 = cur_t;
    exp_lat = 1 + ((nd != d0) ? S + 1 : 0) + ((nt != t0) ? S + 1 : 0);
    div_k = -1; tim_k = -1; done_k = -1; bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) @(negedge clk_in);
      k = cyc - acc;
      if (div_sel !== d0 && div_k < 0) div_k = k;
      if (timpre !== t0 && tim_k < 0) tim_k = k;
      if (busy !== 1'b1 || req_ready !== 1'b0) bad = 1;
      if (upd_done === 1'b1) begin
        done_k = k + 1;
        break;
      end
    end
    chk("done_latency", 32'(done_k), 32'(exp_lat));
    chk("div_change_cycle", 32'(div_k), (nd != d0) ? 32'd1 : 32'hffff_ffff);
    chk("tim_change_cycle", 32'(tim_k),
        (nt != t0) ? ((nd != d0) ? 32'(S + 2) : 32'd1) : 32'hffff_ffff);
    chk("busy_not_ready_during_seq", 32'(bad), 32'd0);
    chk("div_sel_final", 32'(div_sel), 32'(nd));
    chk("timpre_final", 32'(timpre), 32'(nt));
    chk("pclk_log2", 32'(pclk_log2), 32'(ref_pclk(nd)));
    chk("tim_log2", 32'(tim_log2), 32'(ref_tim(nd, nt)));
    @(negedge clk_in);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done_pulse_one_cycle", 32'(upd_done), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    cur_d = nd;
    cur_t = nt;
  endtask

  initial begin
    logic [2:0] nd;
    logic       nt;
    int         w;

    rst_n = 1'b0; req_valid = 1'b0; req_div_sel = 3'b000; req_timpre = 1'b0;
    cur_d = 3'b000; cur_t = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;

    // Reset state
    chk("rst_div_sel", 32'(div_sel), 32'd0);
    chk("rst_timpre", 32'(timpre), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_upd_done", 32'(upd_done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_pclk_log2", 32'(pclk_log2), 32'd0);
    chk("rst_tim_log2", 32'(tim_log2), 32'd0);

    // Single field, then both fields, then an identical request
    start_req(3'b110, 1'b0); monitor(3'b110, 1'b0);
    start_req(3'b111, 1'b1); monitor(3'b111, 1'b1);
    start_req(3'b111, 1'b1); monitor(3'b111, 1'b1);
    start_req(3'b111, 1'b0); monitor(3'b111, 1'b0);

    // Request held valid while busy is ignored, then taken on first idle edge
    start_req(3'b110, 1'b1);
    req_valid = 1'b1; req_div_sel = 3'b100; req_timpre = 1'b0;
    monitor(3'b110, 1'b1);
    @(negedge clk_in);
    acc       = cyc;
    req_valid = 1'b0;
    monitor(3'b100, 1'b0);

    // Random requests, a third of them repeating the current setting
    for (int r = 0; r < 12; r++) begin
      nd = 3'($urandom_range(0, 7));
      nt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        nd = cur_d;
        nt = cur_t;
      end
      w = $urandom_range(0, 4);
      repeat (w) @(negedge clk_in);
      start_req(nd, nt);
      monitor(nd, nt);
    end

    // Reset during WAIT_TIM aborts the sequence
    start_req(cur_d ^ 3'b101, ~cur_t);
    w = 0;
    while (timpre === cur_t && w < 300) begin
      @(negedge clk_in);
      w++;
    end
    chk("abort_reached_wait_tim", 32'(timpre != cur_t), 32'd1);
    repeat (10) @(negedge clk_in);
    rst_n = 1'b0;
    @(negedge clk_in);
    chk("abort_div_sel", 32'(div_sel), 32'd0);
    chk("abort_timpre", 32'(timpre), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_upd_done", 32'(upd_done), 32'd0);
    rst_n = 1'b1;
    cur_d = 3'b000;
    cur_t = 1'b0;
    w = 0;
    for (int i = 0; i < 2 * S + 10; i++) begin
      @(negedge clk_in);
      if (upd_done !== 1'b0 || busy !== 1'b0) w = 1;
    end
    chk("abort_no_late_done", 32'(w), 32'd0);
    start_req(3'b101, 1'b1); monitor(3'b101, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rcc_pclk_div_ctrl.md
Name: rcc_pclk_div_ctrl

Overview:
- Programming-side sequencer for the RCC peripheral-clock divider.
- Accepts prescaler update requests over a valid/ready handshake and drives the divider's div_sel[2:0] and timpre selects one at a time. After each change it holds for a settle window so the downstream glitch-free switches can complete before the next change.
- Reports busy, a completion pulse, and the decoded pclk and timer-kernel divide ratios.
- Runs on the undivided source clock.

Parameters:
- SETTLE_CYC, 64, clk_in cycles held after each select change. Must be ≥ 4× the slowest divided period (/16), so ≥ 64.
- CNT_W, 8, settle counter width. Must satisfy 2^CNT_W > SETTLE_CYC.
- RST_DIV_SEL, 3'b000, div_sel value loaded at reset.

Ports:
- clk_in  input  1  undivided source clock; all logic is on its rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk_in
- req_valid  input  1  update request valid
- req_ready  output  1  controller can accept a request
- req_div_sel  input  3  requested div_sel
- req_timpre  input  1  requested timpre
- div_sel  output  3  registered select to the divider
- timpre  output  1  registered timer-prescaler select to the divider
- busy  output  1  update sequence in progress
- upd_done  output  1  one-cycle pulse when a sequence completes
- pclk_log2  output  3  log2 of the pclk divide ratio (0..4)
- tim_log2  output  3  log2 of the tim_ker_clk divide ratio (0..4)

Behaviour:
- Reset (rst_n=0 at a clk_in edge):
  - div_sel=RST_DIV_SEL, timpre=0, state=IDLE, counter=0.
  - busy=0, upd_done=0, req_ready=1.
  - Reset applied mid-sequence aborts immediately; the pending request is discarded.
- Ratio decode (combinational from the registered div_sel/timpre):
  - pclk_log2: 0 if div_sel[2]=0, else div_sel[1:0]+1.
  - tim_log2 when timpre=0: equals pclk_log2.
  - tim_log2 when timpre=1: if div_sel[2]&div_sel[1], then 1+div_sel[0]; else 0.
- Handshake:
  - req_ready=1 only in IDLE.
  - Transfer occurs when req_valid&req_ready at an edge; req_div_sel and req_timpre are captured into target registers.
  - req_valid while not ready is ignored; no queuing.
- FSM states: IDLE, SW_DIV, WAIT_DIV, SW_TIM, WAIT_TIM, DONE.
  - IDLE, on accept: go to SW_DIV if target div differs from div_sel; else SW_TIM if target timpre differs from timpre; else DONE.
  - SW_DIV: div_sel<=target (one cycle); counter<=0; go to WAIT_DIV.
  - WAIT_DIV: increment counter each cycle. When counter==SETTLE_CYC-1, go to SW_TIM if timpre differs, else DONE.
  - SW_TIM: timpre<=target; counter<=0; go to WAIT_TIM.
  - WAIT_TIM: when counter==SETTLE_CYC-1, go to DONE.
  - DONE: upd_done=1 for exactly one cycle; return to IDLE.
- Ordering: div_sel always changes before timpre, never in the same cycle.
- busy=1 in every state except IDLE. busy and upd_done are both high in DONE.
- Latency from the accept edge to upd_done high:
  - no change: 1 cycle
  - single field changed: SETTLE_CYC+2 cycles
  - both fields changed: 2×SETTLE_CYC+3 cycles
- A request identical to the current setting still completes through DONE and pulses upd_done.
- div_sel and timpre change only at SW_DIV and SW_TIM respectively. Outputs are glitch-free registers.
- The counter never wraps: it is cleared on every SW_* entry and compared for equality only.

Test Plan:
- Reset → div_sel=000, timpre=0, busy=0, req_ready=1, pclk_log2=0, tim_log2=0.
- Request div=3'b110, timpre=0 (SETTLE_CYC=64):
  - div_sel becomes 110 one cycle after accept; upd_done fires 66 cycles after accept.
  - pclk_log2=3, tim_log2=3; timpre never toggles.
- From 110/0, request div=3'b111, timpre=1:
  - div_sel=111 first; timpre rises exactly 65 cycles later; upd_done at 2×64+3=131 cycles.
  - pclk_log2=4, tim_log2=2.
- Identical request while idle → upd_done high 1 cycle after accept; outputs unchanged; busy high for that single cycle.
- req_valid held high with div=100 throughout a busy sequence → req_ready=0 and the request is not captured. It is accepted on the first cycle back in IDLE.
- Assert rst_n=0 during WAIT_TIM → the next edge returns div_sel=000, timpre=0, busy=0; no upd_done pulse.
